// File: rtl/correlator_accumulator.sv
// Integrate-and-dump correlator: code wipe-off, saturating accumulate, dump on strobe.
// Latency: dump_en in cycle N -> dump_valid and new outputs in cycle N+1.
// Backpressure: none; accepts one sample per cycle, and the dump outputs hold until the next dump.
module correlator_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             mix_sign,
  input  logic [2:0]       mix_mag,
  input  logic             code_chip,
  input  logic             dump_en,
  output logic [ACC_W-1:0] accum_out,
  output logic [CNT_W-1:0] count_out,
  output logic             sat_out,
  output logic             dump_valid
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] accum_out_q, accum_out_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             sat_out_q, sat_out_d;
  logic             dump_valid_q, dump_valid_d;

  logic             positive;
  logic [ACC_W:0]   mag_ext;
  logic [ACC_W:0]   term;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_step, acc_fin;
  logic [CNT_W-1:0] cnt_step, cnt_fin;
  logic             sat_step, sat_fin;

  // Wipe-off, one-bit-headroom add with clamp, and interval/dump next-state.
  always_comb begin
    positive = ~(mix_sign ^ code_chip);
    mag_ext  = {{(ACC_W-2){1'b0}}, mix_mag};
    term     = positive ? mag_ext : -mag_ext;
    sum      = {acc_q[ACC_W-1], acc_q} + term;

    // acc and |term| <= 7 always fit in ACC_W+1 bits, so overflow of the
    // ACC_W-bit range shows up as the top two sum bits disagreeing.
    acc_step = sum[ACC_W-1:0];
    sat_step = sat_q;
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat_step = 1'b1;
      acc_step = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    cnt_step = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

    // A sample coincident with dump_en belongs to the interval being closed.
    acc_fin = sample_en ? acc_step : acc_q;
    cnt_fin = sample_en ? cnt_step : cnt_q;
    sat_fin = sample_en ? sat_step : sat_q;

    acc_d        = acc_fin;
    cnt_d        = cnt_fin;
    sat_d        = sat_fin;
    accum_out_d  = accum_out_q;
    count_out_d  = count_out_q;
    sat_out_d    = sat_out_q;
    dump_valid_d = 1'b0;

    if (dump_en) begin
      acc_d        = '0;
      cnt_d        = '0;
      sat_d        = 1'b0;
      accum_out_d  = acc_fin;
      count_out_d  = cnt_fin;
      sat_out_d    = sat_fin;
      dump_valid_d = 1'b1;
    end
  end

  // State and output registers; reset discards any interval or dump in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      accum_out_q  <= '0;
      count_out_q  <= '0;
      sat_out_q    <= 1'b0;
      dump_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      accum_out_q  <= accum_out_d;
      count_out_q  <= count_out_d;
      sat_out_q    <= sat_out_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  assign accum_out  = accum_out_q;
  assign count_out  = count_out_q;
  assign sat_out    = sat_out_q;
  assign dump_valid = dump_valid_q;

endmodule

// File: tb/tb_correlator_accumulator.sv
// Self-checking bench for correlator_accumulator with an 8-bit accumulator and 5-bit counter.
// Expected dumps are queued when dump_en is driven and compared when dump_valid appears.
// Narrow widths let positive/negative clamping and counter saturation show up in short runs.
module tb_correlator_accumulator;
  localparam int ACC_W = 8;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic             mix_sign;
  logic [2:0]       mix_mag;
  logic             code_chip;
  logic             dump_en;
  logic [ACC_W-1:0] accum_out;
  logic [CNT_W-1:0] count_out;
  logic             sat_out;
  logic             dump_valid;

  correlator_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .mix_sign   (mix_sign),
    .mix_mag    (mix_mag),
    .code_chip  (code_chip),
    .dump_en    (dump_en),
    .accum_out  (accum_out),
    .count_out  (count_out),
    .sat_out    (sat_out),
    .dump_valid (dump_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int cnt;
    bit sat;
    int cyc;
  } exp_t;

  typedef struct {
    int n;
    bit sign;
    bit chip;
    int mag;
    int gap;
    bit coinc;
    int exp_acc;
    int exp_cnt;
    bit exp_sat;
  } vec_t;

  exp_t q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_exp = 0;
  int   n_dv = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every dump_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      if (dump_valid) begin
        exp_t e;
        n_dv++;
        if (q.size() == 0) begin
          chk("unexpected_dump_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("dump_latency", cyc, e.cyc);
          chk("accum_out", int'($signed(accum_out)), e.acc);
          chk("count_out", int'(count_out), e.cnt);
          chk("sat_out", int'(sat_out), int'(e.sat));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("missing_dump_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic expect_dump(input int acc, input int cnt, input bit sat);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    e.sat = sat;
    e.cyc = cyc + 1;
    q.push_back(e);
    n_exp++;
  endtask

  task automatic step(input bit se, input bit s, input bit c, input int m, input bit de);
    sample_en = se;
    mix_sign  = s;
    code_chip = c;
    mix_mag   = m[2:0];
    dump_en   = de;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    dump_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic chk_outputs(input string tag, input int acc, input int cnt, input bit sat);
    chk({tag, "_accum"}, int'($signed(accum_out)), acc);
    chk({tag, "_count"}, int'(count_out), cnt);
    chk({tag, "_sat"}, int'(sat_out), int'(sat));
    chk({tag, "_dump_valid"}, int'(dump_valid), 0);
  endtask

  initial begin
    // n, sign, chip, mag, gap, coinc, acc, cnt, sat
    vecs[0] = '{10, 1'b0, 1'b0, 3, 0, 1'b1,  30, 10, 1'b0}; // +3 x10, dump on last sample
    vecs[1] = '{ 2, 1'b1, 1'b0, 1, 0, 1'b0,  -2,  2, 1'b0}; // -1 x2
    vecs[2] = '{30, 1'b1, 1'b1, 6, 0, 1'b0, 127, 30, 1'b1}; // clamps at +127
    vecs[3] = '{ 1, 1'b1, 1'b1, 1, 0, 1'b0,   1,  1, 1'b0}; // fresh interval, sat cleared
    vecs[4] = '{35, 1'b1, 1'b1, 1, 0, 1'b0,  35, 31, 1'b0}; // counter pins at 31, no sat
    vecs[5] = '{ 4, 1'b0, 1'b1, 0, 1, 1'b0,   0,  4, 1'b0}; // magnitude 0 still counts
    vecs[6] = '{ 3, 1'b1, 1'b1, 7, 0, 1'b0,  21,  3, 1'b0}; // illegal mag 7 taken as-is
    vecs[7] = '{ 2, 1'b0, 1'b1, 5, 0, 1'b0, -10,  2, 1'b0}; // illegal mag 5, negative

    rst = 1'b1; sample_en = 1'b0; mix_sign = 1'b0; mix_mag = 3'd0;
    code_chip = 1'b0; dump_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;
    chk_outputs("reset", 0, 0, 1'b0);

    // Load nonzero outputs, then reset mid-interval with a dump and sample in the same cycle.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) expect_dump(30, 5, 1'b0);
      step(1'b1, 1'b1, 1'b1, 6, i == 4);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 6, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 6, 1'b1);
    rst = 1'b0;
    chk_outputs("reset_mid", 0, 0, 1'b0);
    idle(1);
    expect_dump(0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(2);

    // Code wipe-off across all four sign/chip combinations: +6 +3 -2 -1.
    step(1'b1, 1'b1, 1'b1, 6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1, 1'b0);
    expect_dump(6, 4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(1);

    // Uniform-sample intervals from the table.
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        bit last_dump;
        last_dump = vecs[v].coinc && (i == vecs[v].n - 1);
        if (last_dump) expect_dump(vecs[v].exp_acc, vecs[v].exp_cnt, vecs[v].exp_sat);
        step(1'b1, vecs[v].sign, vecs[v].chip, vecs[v].mag, last_dump);
        idle(vecs[v].gap);
      end
      if (!vecs[v].coinc) begin
        expect_dump(vecs[v].exp_acc, vecs[v].exp_cnt, vecs[v].exp_sat);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      end
      idle(1);
    end

    // Outputs hold after the last table dump.
    idle(4);
    chk_outputs("hold_after_table", -10, 2, 1'b0);

    // Negative clamp at -128, then recovery by +6; sticky sat remains.
    for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 1'b0, 6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 6, 1'b0);
    expect_dump(-122, 23, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(1);

    // Sparse samples, then three back-to-back dumps.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 2, 1'b0);
      idle(2);
    end
    expect_dump(14, 7, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    expect_dump(0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    expect_dump(0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(5);
    chk_outputs("hold_after_b2b", 0, 0, 1'b0);

    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    chk("dump_valid_pulses", n_dv, n_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/correlator_accumulator.md
Name: correlator_accumulator

Overview:
- Integrate-and-dump stage directly downstream of the carrier mixer in each tracking channel.
- Takes the mixer's sign/magnitude product (values ±{1,2,3,6}) and wipes off the local code chip.
- Accumulates the signed result over one integration interval.
- On a dump strobe, presents the integrated correlation value, its sample count and a saturation flag to the channel's register/measurement logic.

Parameters:
- ACC_W, 16, accumulator and output width in bits (signed two's complement).
- CNT_W, 14, sample counter width in bits (unsigned).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sample_en  input  1  one-cycle qualifier: the mixer output and code chip are valid this cycle
- mix_sign  input  1  mixer product sign; 1 = positive, 0 = negative
- mix_mag  input  3  mixer product magnitude; legal values 1, 2, 3, 6
- code_chip  input  1  local code chip; 1 = +1, 0 = -1
- dump_en  input  1  one-cycle strobe that ends the current integration interval
- accum_out  output  ACC_W  signed integrated value of the last completed interval
- count_out  output  CNT_W  number of samples in the last completed interval
- sat_out  output  1  last completed interval saturated at least once
- dump_valid  output  1  one-cycle pulse: accum_out, count_out and sat_out were updated

Behaviour:
- Reset (rst=1 at a clk edge):
  - running accumulator, running count, running sat flag, accum_out, count_out, sat_out and dump_valid all go to 0.
  - Reset has priority over everything else, including a dump in progress; the interval in progress is discarded and produces no dump_valid.
- Code wipe-off and sign:
  - positive = ~(mix_sign ^ code_chip).
  - term = +mix_mag if positive, else -mix_mag, sign-extended to ACC_W+1 bits.
  - Illegal mix_mag values (0, 4, 5, 7) are accumulated as-is, with no checking.
- Accumulation, on a cycle with sample_en=1 and dump_en=0:
  - sum = acc + term, computed in ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, acc <= 2^(ACC_W-1)-1 and sat <= 1.
  - If sum < -2^(ACC_W-1), acc <= -2^(ACC_W-1) and sat <= 1.
  - Otherwise acc <= sum.
  - cnt <= cnt+1, saturating at 2^CNT_W-1; counter saturation does not set sat.
- Idle cycle (sample_en=0, dump_en=0): acc, cnt and sat hold.
- Dump cycle (dump_en=1):
  - Final value = the saturated acc+term if sample_en=1 that cycle, else acc. The coincident sample belongs to the interval that is ending.
  - The final count and sat follow the same rule.
  - At the next edge:
    - accum_out, count_out and sat_out <= final values.
    - dump_valid <= 1.
    - acc, cnt and sat <= 0, so the next interval starts empty.
  - Latency: dump_en asserted in cycle N gives dump_valid=1 and new outputs in cycle N+1.
- dump_valid is high for exactly one cycle per dump_en cycle.
- Back-to-back dump_en pulses each produce a dump. A dump with no samples gives accum_out=0, count_out=0, sat_out=0.
- accum_out, count_out and sat_out hold their values between dumps; they are not cleared when dump_valid falls.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: apply rst=1 mid-interval after 5 samples of +6, then release, then dump_en with no samples -> dump_valid one cycle later, accum_out=0, count_out=0, sat_out=0.
- Sign and wipe-off: 4 samples with (mix_sign, code_chip, mix_mag) = (1,1,6), (0,0,3), (1,0,2), (0,1,1), then dump -> accum_out=+6, count_out=4, sat_out=0.
- Coincident sample and dump:
  - 10 samples of +3, with dump_en on the 10th sample's cycle -> accum_out=30, count_out=10.
  - Next interval: 2 samples of -1, then dump -> accum_out=-2, count_out=2.
- Positive saturation, ACC_W=8: 30 samples of +6 -> accum_out=127, count_out=30, sat_out=1. The following interval with 1 sample of +1 -> accum_out=1, sat_out=0.
- Negative saturation and recovery, ACC_W=8: 22 samples of -6 (clamps at -128), then 1 sample of +6 -> accum_out=-122, sat_out=1.
- Gaps and back-to-back dumps:
  - sample_en asserted every 3rd cycle for 7 samples of +2, then dump_en on 3 consecutive cycles with no samples.
  - Expected dump results: (14,7), then (0,0), then (0,0).
  - dump_valid high on 3 consecutive cycles.
  - Outputs hold their values afterwards.
